// File: rtl/mmmu_rx_steer_pkg.sv
// Shared types for the MMMU receive-side steering logic: bridge transaction
// types, default line geometry and the receive FSM state encoding.
package mmmu_rx_steer_pkg;

  typedef enum logic [1:0] {
    csr_read          = 2'd0,
    csr_write         = 2'd1,
    cacheline_rd_resp = 2'd2,
    SPMLEN_spm_write  = 2'd3
  } dbus_meta_t;

  localparam int MMMU_LINE_WORDS = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LINE = 3'd2,
    SPM  = 3'd3,
    SKIP = 3'd4
  } rx_state_t;

endpackage

// File: rtl/mmmu_rx_steer_line.sv
// mmmu_line_assembler: packs cacheline payload words into a line, pulses when
// the last word lands, and flags short/long lines (sticky until reset).
module mmmu_line_assembler #(
  parameter int LINE_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    word_vld_i,
  input  logic [31:0]             word_i,
  input  logic                    fin_i,
  output logic [32*LINE_WORDS-1:0] rdata_o,
  output logic                    rvalid_o,
  output logic                    err_short_o,
  output logic                    err_long_o,
  output logic                    drop_o
);

  localparam int CW = $clog2(LINE_WORDS) + 1;

  logic [CW-1:0]            cnt_q, cnt_d, cnt_eff;
  logic [32*LINE_WORDS-1:0] buf_q, buf_d;
  logic [32*LINE_WORDS-1:0] out_q, out_d;
  logic                     rvalid_q, rvalid_d;
  logic                     short_q, short_d;
  logic                     long_q, long_d;

  // The output copy only updates on completion so dfp_rdata stays stable
  // while the next line is being filled.
  always_comb begin
    cnt_eff  = start_i ? '0 : cnt_q;
    cnt_d    = cnt_eff;
    buf_d    = buf_q;
    out_d    = out_q;
    rvalid_d = 1'b0;
    short_d  = short_q;
    long_d   = long_q;
    drop_o   = 1'b0;
    if (word_vld_i) begin
      if (cnt_eff == CW'(LINE_WORDS)) begin
        long_d = 1'b1;
        drop_o = 1'b1;
      end else begin
        buf_d[32*cnt_eff[CW-2:0] +: 32] = word_i;
        cnt_d = cnt_eff + 1'b1;
        if (cnt_eff == CW'(LINE_WORDS - 1)) begin
          rvalid_d = 1'b1;
          out_d    = buf_d;
        end
      end
    end
    if (fin_i && (cnt_d != CW'(LINE_WORDS))) begin
      short_d = 1'b1;
      drop_o  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      buf_q    <= '0;
      out_q    <= '0;
      rvalid_q <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      out_q    <= out_d;
      rvalid_q <= rvalid_d;
      short_q  <= short_d;
      long_q   <= long_d;
    end
  end

  assign rdata_o     = out_q;
  assign rvalid_o    = rvalid_q;
  assign err_short_o = short_q;
  assign err_long_o  = long_q;

endmodule

// File: rtl/mmmu_rx_steer.sv
// MMMU receive steering: header capture, transaction FSM, scratchpad write path.
// Optional MMMU_RX_STATS_EN adds saturating line/SPM-beat/drop counters.
//
// state | meaning
// IDLE  | waiting for a header beat
// HDR   | header taken, payload routed by recv_type
// LINE  | cacheline payload to line assembler
// SPM   | scratchpad write burst
// SKIP  | csr traffic, ignored until fin
module mmmu_rx_steer
  import mmmu_rx_steer_pkg::*;
#(
  parameter int LINE_WORDS = MMMU_LINE_WORDS,
  parameter int SPM_AW     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              recv_data_i,
  input  logic                     recv_data_vld_i,
  input  dbus_meta_t               recv_type_i,
  input  logic                     recv_fin_i,
  input  logic [8:0]               spm_ilen_m1_i,
  output logic [32*LINE_WORDS-1:0] dfp_rdata_o,
  output logic                     dfp_rvalid_o,
  output logic [31:0]              rx_addr_o,
  output logic [31:0]              spm_wdata_o,
  output logic [SPM_AW-1:0]        spm_waddr_o,
  output logic                     spm_wvalid_o,
  output logic                     spm_wlast_o,
  output logic                     err_short_o,
  output logic                     err_long_o
`ifdef MMMU_RX_STATS_EN
  ,
  output logic [15:0]              stat_lines_o,
  output logic [15:0]              stat_spm_beats_o,
  output logic [15:0]              stat_drops_o
`endif
);

  rx_state_t         state_q, state_d;
  logic [31:0]       rx_addr_q, rx_addr_d;
  logic [SPM_AW-1:0] base_q, base_d;
  logic [8:0]        ilen_q, ilen_d;
  logic [9:0]        j_q, j_d;
  logic              done_q, done_d;
  logic              wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [SPM_AW-1:0] waddr_q, waddr_d;
  logic              spm_short_q, spm_short_d, spm_long_q, spm_long_d;
  logic              spm_drop;
  logic              hdr_beat, line_ctx, spm_ctx, line_fin, line_drop;
  logic              line_short, line_long;

  assign hdr_beat = (state_q == IDLE) && recv_data_vld_i;
  assign line_ctx = (state_q == LINE) || ((state_q == HDR) && (recv_type_i == cacheline_rd_resp));
  assign spm_ctx  = (state_q == SPM)  || ((state_q == HDR) && (recv_type_i == SPMLEN_spm_write));
  assign line_fin = recv_fin_i && (line_ctx || (hdr_beat && (recv_type_i == cacheline_rd_resp)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (recv_data_vld_i) state_d = recv_fin_i ? IDLE : HDR;
      HDR: begin
        if (recv_fin_i)                             state_d = IDLE;
        else if (recv_type_i == cacheline_rd_resp)  state_d = LINE;
        else if (recv_type_i == SPMLEN_spm_write)   state_d = SPM;
        else                                        state_d = SKIP;
      end
      LINE, SPM, SKIP: if (recv_fin_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_addr_d   = rx_addr_q;
    base_d      = base_q;
    ilen_d      = ilen_q;
    j_d         = j_q;
    done_d      = done_q;
    wvalid_d    = 1'b0;
    wlast_d     = 1'b0;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    spm_short_d = spm_short_q;
    spm_long_d  = spm_long_q;
    spm_drop    = 1'b0;
    if (hdr_beat) begin
      rx_addr_d = recv_data_i;
      base_d    = recv_data_i[SPM_AW-1:0];
      ilen_d    = spm_ilen_m1_i;
      j_d       = '0;
      done_d    = 1'b0;
      if (recv_fin_i && (recv_type_i == SPMLEN_spm_write)) begin
        spm_short_d = 1'b1;
        spm_drop    = 1'b1;
      end
    end
    if (spm_ctx && recv_data_vld_i) begin
      if (done_q) begin
        spm_long_d = 1'b1;
        spm_drop   = 1'b1;
      end else begin
        wvalid_d = 1'b1;
        wdata_d  = recv_data_i;
        waddr_d  = base_q + SPM_AW'(j_q);
        wlast_d  = (j_q == {1'b0, ilen_q});
        done_d   = wlast_d;
        j_d      = j_q + 10'd1;
      end
    end
    if (spm_ctx && recv_fin_i && !done_d) begin
      spm_short_d = 1'b1;
      spm_drop    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rx_addr_q   <= '0;
      base_q      <= '0;
      ilen_q      <= '0;
      j_q         <= '0;
      done_q      <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      spm_short_q <= 1'b0;
      spm_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_addr_q   <= rx_addr_d;
      base_q      <= base_d;
      ilen_q      <= ilen_d;
      j_q         <= j_d;
      done_q      <= done_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      spm_short_q <= spm_short_d;
      spm_long_q  <= spm_long_d;
    end
  end

  mmmu_line_assembler #(.LINE_WORDS(LINE_WORDS)) u_line (
    .clk         (clk),
    .rst         (rst),
    .start_i     (hdr_beat),
    .word_vld_i  (line_ctx && recv_data_vld_i),
    .word_i      (recv_data_i),
    .fin_i       (line_fin),
    .rdata_o     (dfp_rdata_o),
    .rvalid_o    (dfp_rvalid_o),
    .err_short_o (line_short),
    .err_long_o  (line_long),
    .drop_o      (line_drop)
  );

  assign rx_addr_o    = rx_addr_q;
  assign spm_wdata_o  = wdata_q;
  assign spm_waddr_o  = waddr_q;
  assign spm_wvalid_o = wvalid_q;
  assign spm_wlast_o  = wlast_q;
  assign err_short_o  = line_short | spm_short_q;
  assign err_long_o   = line_long | spm_long_q;

`ifdef MMMU_RX_STATS_EN
  logic [15:0] stat_lines_q, stat_spm_q, stat_drops_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_lines_q <= '0;
      stat_spm_q   <= '0;
      stat_drops_q <= '0;
    end else begin
      if (dfp_rvalid_o && (stat_lines_q != 16'hFFFF)) stat_lines_q <= stat_lines_q + 16'd1;
      if (wvalid_q && (stat_spm_q != 16'hFFFF))       stat_spm_q   <= stat_spm_q + 16'd1;
      if ((line_drop || spm_drop) && (stat_drops_q != 16'hFFFF))
        stat_drops_q <= stat_drops_q + 16'd1;
    end
  end

  assign stat_lines_o     = stat_lines_q;
  assign stat_spm_beats_o = stat_spm_q;
  assign stat_drops_o     = stat_drops_q;
`else
  logic stats_unused;
  assign stats_unused = line_drop | spm_drop;
`endif

endmodule

// File: tb/tb_mmmu_rx_steer.sv
// Bench for mmmu_rx_steer: directed cases plus randomized transactions checked
// against a per-transaction model of expected line pulses, SPM beats and errors.
module tb_mmmu_rx_steer;
  import mmmu_rx_steer_pkg::*;

  localparam int LW = 8;
  localparam int AW = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      recv_data = '0;
  logic             recv_data_vld = 1'b0;
  dbus_meta_t       recv_type = csr_read;
  logic             recv_fin = 1'b0;
  logic [8:0]       spm_ilen_m1 = '0;
  logic [32*LW-1:0] dfp_rdata;
  logic             dfp_rvalid;
  logic [31:0]      rx_addr;
  logic [31:0]      spm_wdata;
  logic [AW-1:0]    spm_waddr;
  logic             spm_wvalid, spm_wlast, err_short, err_long;
`ifdef MMMU_RX_STATS_EN
  logic [15:0]      stat_lines, stat_spm_beats, stat_drops;
`endif

  always #5 clk = ~clk;

  mmmu_rx_steer #(.LINE_WORDS(LW), .SPM_AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .recv_data_i     (recv_data),
    .recv_data_vld_i (recv_data_vld),
    .recv_type_i     (recv_type),
    .recv_fin_i      (recv_fin),
    .spm_ilen_m1_i   (spm_ilen_m1),
    .dfp_rdata_o     (dfp_rdata),
    .dfp_rvalid_o    (dfp_rvalid),
    .rx_addr_o       (rx_addr),
    .spm_wdata_o     (spm_wdata),
    .spm_waddr_o     (spm_waddr),
    .spm_wvalid_o    (spm_wvalid),
    .spm_wlast_o     (spm_wlast),
    .err_short_o     (err_short),
    .err_long_o      (err_long)
`ifdef MMMU_RX_STATS_EN
    ,
    .stat_lines_o     (stat_lines),
    .stat_spm_beats_o (stat_spm_beats),
    .stat_drops_o     (stat_drops)
`endif
  );

  int n_err = 0;
  int n_chk = 0;

  logic [32*LW-1:0] got_line[$];
  logic [44:0]      got_spm[$];
  logic [32*LW-1:0] exp_line[$];
  logic [44:0]      exp_spm[$];
  logic             exp_short = 1'b0;
  logic             exp_long  = 1'b0;
  logic [31:0]      exp_addr  = '0;

  always @(negedge clk) begin
    if (dfp_rvalid) got_line.push_back(dfp_rdata);
    if (spm_wvalid) got_spm.push_back({spm_wlast, spm_waddr, spm_wdata});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    got_line.delete(); got_spm.delete(); exp_line.delete(); exp_spm.delete();
    exp_short = 1'b0; exp_long = 1'b0; exp_addr = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rvalid"}, 256'(dfp_rvalid), 256'(0));
    check({tag, ".rdata"},  256'(dfp_rdata),  256'(0));
    check({tag, ".rx_addr"}, 256'(rx_addr),   256'(0));
    check({tag, ".wvalid"}, 256'(spm_wvalid), 256'(0));
    check({tag, ".wdata"},  256'(spm_wdata),  256'(0));
    check({tag, ".waddr"},  256'(spm_waddr),  256'(0));
    check({tag, ".wlast"},  256'(spm_wlast),  256'(0));
    check({tag, ".err_s"},  256'(err_short),  256'(0));
    check({tag, ".err_l"},  256'(err_long),   256'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0; recv_data_vld = 1'b0; recv_fin = 1'b0;
    step();
    rst = 1'b1;
    clear_model();
  endtask

  // Model: a line pulses once iff at least LW payload words arrive; an SPM
  // burst writes the first ilen+1 beats at (header+j) mod 2^AW.
  task automatic send(input dbus_meta_t t, input logic [31:0] hdr, input int n,
                      input bit fin_sep, input int gap_max, input logic [8:0] ilen,
                      input bit count_words);
    logic [31:0]      w[$];
    logic [32*LW-1:0] l;
    logic [AW-1:0]    a;
    int               m;
    for (int i = 0; i < n; i++) w.push_back(count_words ? 32'(i + 1) : $urandom());
    exp_addr = hdr;
    if (t == cacheline_rd_resp) begin
      if (n >= LW) begin
        l = '0;
        for (int k = 0; k < LW; k++) l[32*k +: 32] = w[k];
        exp_line.push_back(l);
        if (n > LW) exp_long = 1'b1;
      end else exp_short = 1'b1;
    end else if (t == SPMLEN_spm_write) begin
      m = int'(ilen) + 1;
      for (int j = 0; j < n && j < m; j++) begin
        a = hdr[AW-1:0] + AW'(j);
        exp_spm.push_back({(j == m - 1), a, w[j]});
      end
      if (n < m) exp_short = 1'b1;
      if (n > m) exp_long = 1'b1;
    end
    spm_ilen_m1 = ilen; recv_type = t;
    recv_data_vld = 1'b1; recv_data = hdr; recv_fin = (n == 0) && !fin_sep;
    step();
    spm_ilen_m1 = 9'($urandom());
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          recv_data_vld = 1'b0; recv_fin = 1'b0; step();
        end
      end
      recv_data_vld = 1'b1; recv_data = w[i]; recv_fin = (i == n - 1) && !fin_sep;
      step();
    end
    if (fin_sep) begin
      recv_data_vld = 1'b0; recv_fin = 1'b1; step();
    end
    recv_data_vld = 1'b0; recv_fin = 1'b0;
  endtask

  task automatic verify(input string tag);
    int nl, ns;
    repeat (3) step();
    check({tag, ".lines"}, 256'(got_line.size()), 256'(exp_line.size()));
    nl = (got_line.size() < exp_line.size()) ? got_line.size() : exp_line.size();
    for (int i = 0; i < nl; i++) check($sformatf("%s.line%0d", tag, i), got_line[i], exp_line[i]);
    check({tag, ".beats"}, 256'(got_spm.size()), 256'(exp_spm.size()));
    ns = (got_spm.size() < exp_spm.size()) ? got_spm.size() : exp_spm.size();
    for (int i = 0; i < ns; i++) check($sformatf("%s.beat%0d", tag, i), 256'(got_spm[i]), 256'(exp_spm[i]));
    check({tag, ".err_s"},   256'(err_short), 256'(exp_short));
    check({tag, ".err_l"},   256'(err_long),  256'(exp_long));
    check({tag, ".rx_addr"}, 256'(rx_addr),   256'(exp_addr));
    got_line.delete(); got_spm.delete(); exp_line.delete(); exp_spm.delete();
  endtask

  initial begin
    repeat (3) step();
    check_zero("reset");
    rst = 1'b1;
    step();

    send(cacheline_rd_resp, 32'h0000_1000, 8, 1'b0, 0, 9'd0, 1'b1);
    repeat (3) step();
    check("t1.lines", 256'(got_line.size()), 256'(1));
    if (got_line.size() > 0) begin
      check("t1.w0", 256'(got_line[0][31:0]), 256'(1));
      check("t1.w7", 256'(got_line[0][255:224]), 256'(8));
    end
    check("t1.rx_addr", 256'(rx_addr), 256'(32'h1000));
    check("t1.err_s", 256'(err_short), 256'(0));
    check("t1.err_l", 256'(err_long), 256'(0));
    got_line.delete(); exp_line.delete();

    send(SPMLEN_spm_write, 32'h1f0, 8, 1'b0, 1, 9'd7, 1'b0);
    verify("t2");

    send(cacheline_rd_resp, 32'h2000, 5, 1'b0, 0, 9'd0, 1'b0);
    send(cacheline_rd_resp, 32'h3000, 8, 1'b1, 1, 9'd0, 1'b0);
    verify("t3");

    do_reset();
    send(SPMLEN_spm_write, 32'h200, 6, 1'b0, 0, 9'd3, 1'b0);
    verify("t4a");
    send(SPMLEN_spm_write, 32'hFFF, 6, 1'b1, 0, 9'd3, 1'b0);
    verify("t4b");

    send(csr_write, 32'h1f0, 2, 1'b0, 0, 9'd7, 1'b0);
    send(cacheline_rd_resp, 32'h4000, 8, 1'b0, 0, 9'd0, 1'b0);
    verify("t5");

    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) do_reset();
      send(dbus_meta_t'($urandom_range(3, 0)), $urandom(), $urandom_range(12, 0),
           1'($urandom_range(1, 0)), $urandom_range(2, 0), 9'($urandom_range(10, 0)), 1'b0);
      verify($sformatf("rnd%0d", t));
    end

    send(cacheline_rd_resp, 32'h5000, 8, 1'b0, 0, 9'd0, 1'b0);
    verify("t6pre");
    recv_type = cacheline_rd_resp;
    recv_data_vld = 1'b1; recv_data = 32'h6000; recv_fin = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      recv_data = $urandom();
      if (i == 3) rst = 1'b0;
      step();
    end
    recv_data_vld = 1'b0;
    check_zero("t6rst");
    rst = 1'b1;
    clear_model();
    step();
    send(cacheline_rd_resp, 32'h7000, 8, 1'b0, 0, 9'd0, 1'b0);
    verify("t6");
`ifdef MMMU_RX_STATS_EN
    check("t6.stat_lines", 256'(stat_lines), 256'(1));
    check("t6.stat_spm", 256'(stat_spm_beats), 256'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
